// File: rtl/ex_stage.sv
// ex_stage: execute stage of the RV32I five-stage pipeline.
// Selects forwarded operands, runs the ALU, resolves branches and jumps
// (driving a same-cycle redirect to fetch) and registers the results
// into the EX/MEM pipeline register with hold and bubble control.

module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            stallM,
    input  logic            clrM,

    input  logic            RegwriteE,
    input  logic            MemwriteE,
    input  logic            alusrcE,
    input  logic            jalE,
    input  logic            jalrE,
    input  logic            branchE,
    input  logic            loadE,
    input  logic            storeE,
    input  logic [2:0]      resultsrcE,
    input  logic [2:0]      load_srcE,
    input  logic [1:0]      store_srcE,
    input  logic [3:0]      alucontrolE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] Rd1E,
    input  logic [XLEN-1:0] Rd2E,
    input  logic [XLEN-1:0] ImmextE,
    input  logic [XLEN-1:0] PcE,
    input  logic [XLEN-1:0] Pcplus4E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,

    output logic            PcsrcE,
    output logic [XLEN-1:0] PctargetE,

    output logic            RegwriteM,
    output logic            MemwriteM,
    output logic            loadM,
    output logic            storeM,
    output logic [2:0]      resultsrcM,
    output logic [2:0]      load_srcM,
    output logic [1:0]      store_srcM,
    output logic [XLEN-1:0] AluresultM,
    output logic [XLEN-1:0] WritedataM,
    output logic [XLEN-1:0] Pcplus4M,
    output logic [4:0]      RdM
);

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_LUI   = 4'b1010,
        ALU_AUIPC = 4'b1011
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_cond_t;

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      shamt;
    logic            lt_signed;
    logic            lt_unsigned;
    logic            cond_true;
    logic            br_lt_signed;
    logic            br_lt_unsigned;

    // Forward mux for operand A; the unused select code falls back to the register value.
    always_comb begin
        src_a = Rd1E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = AluresultM;
            default: src_a = Rd1E;
        endcase
    end

    // Forward mux for operand B; this value is also the store data sent to MEM.
    always_comb begin
        write_data = Rd2E;
        case (ForwardBE)
            2'b01:   write_data = ResultW;
            2'b10:   write_data = AluresultM;
            default: write_data = Rd2E;
        endcase
    end

    assign src_b       = alusrcE ? ImmextE : write_data;
    assign shamt       = src_b[4:0];
    assign lt_signed   = $signed(src_a) < $signed(src_b);
    assign lt_unsigned = src_a < src_b;

    // ALU: all arithmetic wraps at 32 bits; reserved opcodes produce zero.
    always_comb begin
        alu_result = '0;
        case (alu_op_t'(alucontrolE))
            ALU_ADD:   alu_result = src_a + src_b;
            ALU_SUB:   alu_result = src_a - src_b;
            ALU_AND:   alu_result = src_a & src_b;
            ALU_OR:    alu_result = src_a | src_b;
            ALU_XOR:   alu_result = src_a ^ src_b;
            ALU_SLL:   alu_result = src_a << shamt;
            ALU_SRL:   alu_result = src_a >> shamt;
            ALU_SRA:   alu_result = $unsigned($signed(src_a) >>> shamt);
            ALU_SLT:   alu_result = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU:  alu_result = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_LUI:   alu_result = src_b;
            ALU_AUIPC: alu_result = PcE + src_b;
            default:   alu_result = '0;
        endcase
    end

    // Branch compares always use the forwarded register operands, never the immediate.
    assign br_lt_signed   = $signed(src_a) < $signed(write_data);
    assign br_lt_unsigned = src_a < write_data;

    // Branch condition evaluation; funct3 010/011 are not branches and never take.
    always_comb begin
        cond_true = 1'b0;
        case (br_cond_t'(funct3E))
            BR_EQ:   cond_true = (src_a == write_data);
            BR_NE:   cond_true = (src_a != write_data);
            BR_LT:   cond_true = br_lt_signed;
            BR_GE:   cond_true = ~br_lt_signed;
            BR_LTU:  cond_true = br_lt_unsigned;
            BR_GEU:  cond_true = ~br_lt_unsigned;
            default: cond_true = 1'b0;
        endcase
    end

    // Same-cycle redirect; jalr takes precedence and clears bit 0 of its target.
    always_comb begin
        PcsrcE = jalE | jalrE | (branchE & cond_true);
        if (jalrE) begin
            PctargetE = (src_a + ImmextE) & ~{{(XLEN-1){1'b0}}, 1'b1};
        end else begin
            PctargetE = PcE + ImmextE;
        end
    end

    // EX/MEM register: async clear on reset, bubble beats hold, otherwise capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegwriteM  <= 1'b0;
            MemwriteM  <= 1'b0;
            loadM      <= 1'b0;
            storeM     <= 1'b0;
            resultsrcM <= '0;
            load_srcM  <= '0;
            store_srcM <= '0;
            AluresultM <= '0;
            WritedataM <= '0;
            Pcplus4M   <= '0;
            RdM        <= '0;
        end else if (clrM) begin
            RegwriteM  <= 1'b0;
            MemwriteM  <= 1'b0;
            loadM      <= 1'b0;
            storeM     <= 1'b0;
            resultsrcM <= '0;
            load_srcM  <= '0;
            store_srcM <= '0;
            AluresultM <= '0;
            WritedataM <= '0;
            Pcplus4M   <= '0;
            RdM        <= '0;
        end else if (!stallM) begin
            RegwriteM  <= RegwriteE;
            MemwriteM  <= MemwriteE;
            loadM      <= loadE;
            storeM     <= storeE;
            resultsrcM <= resultsrcE;
            load_srcM  <= load_srcE;
            store_srcM <= store_srcE;
            AluresultM <= alu_result;
            WritedataM <= write_data;
            Pcplus4M   <= Pcplus4E;
            RdM        <= RdE;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: self-checking bench for ex_stage. Directed scenarios plus
// randomized cycles compared against a behavioural model of the stage.

module tb_ex_stage;

    logic        clk;
    logic        rst;
    logic        stallM, clrM;
    logic        RegwriteE, MemwriteE, alusrcE, jalE, jalrE, branchE, loadE, storeE;
    logic [2:0]  resultsrcE, load_srcE;
    logic [1:0]  store_srcE;
    logic [3:0]  alucontrolE;
    logic [2:0]  funct3E;
    logic [31:0] Rd1E, Rd2E, ImmextE, PcE, Pcplus4E;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;

    logic        PcsrcE;
    logic [31:0] PctargetE;
    logic        RegwriteM, MemwriteM, loadM, storeM;
    logic [2:0]  resultsrcM, load_srcM;
    logic [1:0]  store_srcM;
    logic [31:0] AluresultM, WritedataM, Pcplus4M;
    logic [4:0]  RdM;

    int checks   = 0;
    int failures = 0;

    // Model of the EX/MEM register, same field order as mActual.
    logic [112:0] mExp;
    logic [112:0] mActual;
    logic [32:0]  rExp;

    assign mActual = {RegwriteM, MemwriteM, loadM, storeM, resultsrcM, load_srcM,
                      store_srcM, AluresultM, WritedataM, Pcplus4M, RdM};

    ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stallM(stallM), .clrM(clrM),
        .RegwriteE(RegwriteE), .MemwriteE(MemwriteE), .alusrcE(alusrcE),
        .jalE(jalE), .jalrE(jalrE), .branchE(branchE), .loadE(loadE), .storeE(storeE),
        .resultsrcE(resultsrcE), .load_srcE(load_srcE), .store_srcE(store_srcE),
        .alucontrolE(alucontrolE), .funct3E(funct3E),
        .Rd1E(Rd1E), .Rd2E(Rd2E), .ImmextE(ImmextE), .PcE(PcE), .Pcplus4E(Pcplus4E),
        .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PcsrcE(PcsrcE), .PctargetE(PctargetE),
        .RegwriteM(RegwriteM), .MemwriteM(MemwriteM), .loadM(loadM), .storeM(storeM),
        .resultsrcM(resultsrcM), .load_srcM(load_srcM), .store_srcM(store_srcM),
        .AluresultM(AluresultM), .WritedataM(WritedataM), .Pcplus4M(Pcplus4M), .RdM(RdM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] regv);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return mExp[100:69];
        return regv;
    endfunction

    function automatic logic signed_less(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = b % 32;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + (~b + 32'd1);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd8:  return signed_less(a, b) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return b;
            4'd11: return PcE + b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic branch_ref(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return signed_less(a, b);
            3'd5: return !signed_less(a, b);
            3'd6: return a < b;
            3'd7: return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [32:0] redirect_ref();
        logic [31:0] sa, wd, tgt;
        logic        taken;
        sa    = fwd_ref(ForwardAE, Rd1E);
        wd    = fwd_ref(ForwardBE, Rd2E);
        taken = jalE || jalrE || (branchE && branch_ref(funct3E, sa, wd));
        tgt   = jalrE ? (((sa + ImmextE) >> 1) << 1) : (PcE + ImmextE);
        return {taken, tgt};
    endfunction

    function automatic logic [112:0] capture_ref();
        logic [31:0] sa, wd, sb;
        sa = fwd_ref(ForwardAE, Rd1E);
        wd = fwd_ref(ForwardBE, Rd2E);
        sb = alusrcE ? ImmextE : wd;
        return {RegwriteE, MemwriteE, loadE, storeE, resultsrcE, load_srcE, store_srcE,
                alu_ref(alucontrolE, sa, sb), wd, Pcplus4E, RdE};
    endfunction

    // Advance one rising edge and move the model along with it.
    task automatic tick();
        logic [112:0] nxt;
        if (clrM)        nxt = '0;
        else if (stallM) nxt = mExp;
        else             nxt = capture_ref();
        @(posedge clk);
        if (rst) mExp = nxt;
        #1;
    endtask

    task automatic clear_inputs();
        stallM = 0; clrM = 0;
        RegwriteE = 0; MemwriteE = 0; alusrcE = 0; jalE = 0; jalrE = 0;
        branchE = 0; loadE = 0; storeE = 0;
        resultsrcE = 0; load_srcE = 0; store_srcE = 0;
        alucontrolE = 0; funct3E = 0;
        Rd1E = 0; Rd2E = 0; ImmextE = 0; PcE = 0; Pcplus4E = 0; RdE = 0;
        ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    task automatic drive_random();
        RegwriteE = 1'($urandom); MemwriteE = 1'($urandom); alusrcE = 1'($urandom);
        jalE    = ($urandom_range(0, 7) == 0);
        jalrE   = ($urandom_range(0, 7) == 0);
        branchE = 1'($urandom);
        loadE = 1'($urandom); storeE = 1'($urandom);
        resultsrcE = 3'($urandom); load_srcE = 3'($urandom); store_srcE = 2'($urandom);
        alucontrolE = 4'($urandom); funct3E = 3'($urandom);
        Rd1E = $urandom;
        Rd2E = ($urandom_range(0, 3) == 0) ? Rd1E : $urandom;
        ImmextE = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
        PcE = $urandom; Pcplus4E = PcE + 32'd4;
        RdE = 5'($urandom);
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
        ResultW = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        mExp = '0;
        @(negedge clk);
        drive_random();
        clrM = 0; stallM = 0;
        tick();
        @(negedge clk);
        checks++;
        if (mActual !== 113'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got %h expected 0", mActual);
        end
        rst = 1'b1;
        clear_inputs();
    endtask

    task automatic test_alu_directed();
        // ADD 5 + 7, register operands
        @(negedge clk);
        clear_inputs();
        Rd1E = 32'd5; Rd2E = 32'd7; RdE = 5'd9; RegwriteE = 1;
        Pcplus4E = 32'h104; resultsrcE = 3'd1;
        tick();
        checks++;
        if (AluresultM !== 32'd12 || WritedataM !== 32'd7 || RdM !== 5'd9) begin
            failures++;
            $display("[TB] FAIL add: got alu=%h wd=%h rd=%0d expected 0000000c/00000007/9",
                     AluresultM, WritedataM, RdM);
        end
        checks++;
        if (mActual !== mExp) begin
            failures++;
            $display("[TB] FAIL add_fields: got %h expected %h", mActual, mExp);
        end
        // SRA of 0x80000000 by immediate 4
        @(negedge clk);
        clear_inputs();
        Rd1E = 32'h8000_0000; alusrcE = 1; ImmextE = 32'd4; alucontrolE = 4'd7;
        tick();
        checks++;
        if (AluresultM !== 32'hF800_0000) begin
            failures++;
            $display("[TB] FAIL sra: got %h expected f8000000", AluresultM);
        end
        // SLTU 1 < 0xFFFFFFFF
        @(negedge clk);
        Rd1E = 32'd1; ImmextE = 32'hFFFF_FFFF; alucontrolE = 4'd9;
        tick();
        checks++;
        if (AluresultM !== 32'd1) begin
            failures++;
            $display("[TB] FAIL sltu: got %h expected 00000001", AluresultM);
        end
        // SLT 1 < -1 signed is false
        @(negedge clk);
        alucontrolE = 4'd8;
        tick();
        checks++;
        if (AluresultM !== 32'd0) begin
            failures++;
            $display("[TB] FAIL slt: got %h expected 00000000", AluresultM);
        end
    endtask

    task automatic test_forwarding();
        @(negedge clk);
        clear_inputs();
        Rd1E = 32'd60; Rd2E = 32'd40;
        tick();
        checks++;
        if (AluresultM !== 32'd100) begin
            failures++;
            $display("[TB] FAIL fwd_setup: got %h expected 00000064", AluresultM);
        end
        @(negedge clk);
        Rd1E = 32'hDEAD_0000; Rd2E = 32'hBEEF_0000;
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd3; alucontrolE = 4'd1;
        tick();
        checks++;
        if (AluresultM !== 32'd97 || WritedataM !== 32'd3) begin
            failures++;
            $display("[TB] FAIL fwd_sub: got alu=%h wd=%h expected 00000061/00000003",
                     AluresultM, WritedataM);
        end
        // select code 11 behaves as register value, store data is not the immediate
        @(negedge clk);
        ForwardAE = 2'b11; ForwardBE = 2'b11; alucontrolE = 4'd0;
        Rd1E = 32'd10; Rd2E = 32'd20; alusrcE = 1; ImmextE = 32'd5;
        tick();
        checks++;
        if (AluresultM !== 32'd15 || WritedataM !== 32'd20) begin
            failures++;
            $display("[TB] FAIL fwd_11: got alu=%h wd=%h expected 0000000f/00000014",
                     AluresultM, WritedataM);
        end
    endtask

    task automatic test_branch();
        @(negedge clk);
        clear_inputs();
        branchE = 1; funct3E = 3'b101; Rd1E = 32'hFFFF_FFFF; Rd2E = 32'd0;
        PcE = 32'h0000_2000; ImmextE = 32'h0000_0040;
        #1;
        checks++;
        if (PcsrcE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bge_neg: got %b expected 0", PcsrcE);
        end
        funct3E = 3'b110;
        #1;
        checks++;
        if (PcsrcE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bltu_max: got %b expected 0", PcsrcE);
        end
        funct3E = 3'b111;
        #1;
        checks++;
        if (PcsrcE !== 1'b1 || PctargetE !== 32'h0000_2040) begin
            failures++;
            $display("[TB] FAIL bgeu_max: got %b/%h expected 1/00002040", PcsrcE, PctargetE);
        end
        funct3E = 3'b010;
        Rd2E = Rd1E;
        #1;
        checks++;
        if (PcsrcE !== 1'b0) begin
            failures++;
            $display("[TB] FAIL f3_010: got %b expected 0", PcsrcE);
        end
        branchE = 0; jalE = 1; jalrE = 1; Rd1E = 32'h0000_1001; ImmextE = 32'd2;
        #1;
        checks++;
        if (PcsrcE !== 1'b1 || PctargetE !== 32'h0000_1002) begin
            failures++;
            $display("[TB] FAIL jalr: got %b/%h expected 1/00001002", PcsrcE, PctargetE);
        end
        jalrE = 0;
        #1;
        checks++;
        if (PcsrcE !== 1'b1 || PctargetE !== 32'h0000_2002) begin
            failures++;
            $display("[TB] FAIL jal: got %b/%h expected 1/00002002", PcsrcE, PctargetE);
        end
        tick();
    endtask

    task automatic test_stall_clear();
        logic [112:0] held;
        @(negedge clk);
        drive_random();
        stallM = 0; clrM = 0; RdE = 5'd17; RegwriteE = 1;
        tick();
        held = mExp;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_random();
            stallM = 1; clrM = 0;
            tick();
            checks++;
            if (mActual !== held) begin
                failures++;
                $display("[TB] FAIL stall_hold%0d: got %h expected %h", i, mActual, held);
            end
        end
        @(negedge clk);
        drive_random();
        stallM = 1; clrM = 1;
        tick();
        checks++;
        if (mActual !== 113'd0) begin
            failures++;
            $display("[TB] FAIL stall_clr: got %h expected 0", mActual);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive_random();
        stallM = 0; clrM = 0; RegwriteE = 1; RdE = 5'd3; Pcplus4E = 32'h44;
        tick();
        #2;
        rst = 1'b0;
        mExp = '0;
        #1;
        checks++;
        if (mActual !== 113'd0) begin
            failures++;
            $display("[TB] FAIL async_rst: got %h expected 0", mActual);
        end
        @(negedge clk);
        drive_random();
        stallM = 0; clrM = 0;
        tick();
        checks++;
        if (mActual !== 113'd0) begin
            failures++;
            $display("[TB] FAIL rst_held: got %h expected 0", mActual);
        end
        @(negedge clk);
        rst = 1'b1;
        drive_random();
        stallM = 0; clrM = 0; RegwriteE = 1; Pcplus4E = 32'h88;
        tick();
        checks++;
        if (mActual !== mExp || Pcplus4M !== 32'h88) begin
            failures++;
            $display("[TB] FAIL rst_resume: got %h expected %h", mActual, mExp);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive_random();
            stallM = ($urandom_range(0, 7) == 0);
            clrM   = ($urandom_range(0, 11) == 0);
            #1;
            rExp = redirect_ref();
            checks++;
            if ({PcsrcE, PctargetE} !== rExp) begin
                failures++;
                $display("[TB] FAIL rand_redirect%0d: got %b/%h expected %b/%h",
                         i, PcsrcE, PctargetE, rExp[32], rExp[31:0]);
            end
            tick();
            checks++;
            if (mActual !== mExp) begin
                failures++;
                $display("[TB] FAIL rand_mreg%0d: got %h expected %h", i, mActual, mExp);
            end
        end
    endtask

    task automatic test_back_to_back();
        // consecutive forwarding from the previous ALU result
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_random();
            stallM = 0; clrM = 0; alusrcE = 0;
            ForwardAE = 2'b10; ForwardBE = 2'b10;
            alucontrolE = 4'($urandom_range(0, 4));
            tick();
            checks++;
            if (mActual !== mExp) begin
                failures++;
                $display("[TB] FAIL b2b%0d: got %h expected %h", i, mActual, mExp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_forwarding();
        test_branch();
        test_stall_clear();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
